mod_m_counter_prog: RTL

//   Runtime-programmable mod-M counter.
//   - Adds up/down counting, count enable, synchronous clear, parallel load and a shadowed modulus

---
 rtl/mod_cnt_pkg.sv | 11 +
 rtl/mod_m_prescaler.sv | 29 ++
 rtl/mod_m_counter_prog.sv | 118 +++++++++++
 3 files changed

// File: rtl/mod_cnt_pkg.sv
// Shared types and helpers for the programmable mod-M counter.
package mod_cnt_pkg;

    typedef enum logic {DIR_DOWN, DIR_UP} cnt_dir_t;

    // Loads at or above the modulus land on the last legal count.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] m);
        return (val >= m) ? (m - 32'd1) : val;
    endfunction

endpackage

// File: rtl/mod_m_prescaler.sv
// Enable divider: tick is high on one of every PRESCALE enabled cycles.
module mod_m_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= RELOAD;
        end else if (clr) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : (cnt - CW'(1));
        end
    end

endmodule

// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable mod-M up/down counter with shadowed modulus and wrap pulse.
// Optional enable prescaler is built only when MODCNT_PRESCALE_EN is defined.
module mod_m_counter_prog #(
    parameter int W         = 8,
    parameter int M_DEFAULT = 10,
    parameter int PRESCALE  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         m_wr,
    input  logic [W-1:0] m_val,
    output logic         m_pend,
    output logic [W-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap
);

    import mod_cnt_pkg::*;

    localparam logic [W-1:0] M_RST = W'(M_DEFAULT);

    logic [W-1:0] m_reg;
    logic [W-1:0] shadow;
    logic [W-1:0] m_last;
    logic [W-1:0] m_next;
    logic [W-1:0] shadow_next;
    logic [W-1:0] q_next;
    logic [W-1:0] q_load;
    logic         pend_next;
    logic         step_en;
    logic         step;
    logic         at_edge;
    logic         wrap_step;
    logic         m_ok;
    logic         boundary;
    cnt_dir_t     dir;

`ifdef MODCNT_PRESCALE_EN
    mod_m_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .tick  (step_en)
    );
`else
    localparam int unused_prescale = PRESCALE;
    assign step_en = en;
`endif

    assign dir       = up ? DIR_UP : DIR_DOWN;
    assign m_last    = m_reg - W'(1);
    assign max_tick  = (q == m_last);
    assign min_tick  = (q == '0);
    assign step      = step_en && !clr && !load;
    assign at_edge   = (dir == DIR_UP) ? (q == m_last) : (q == '0);
    assign wrap_step = step && at_edge;
    assign m_ok      = m_wr && (m_val >= W'(2));
    assign boundary  = clr || wrap_step;
    assign q_load    = W'(clamp_load(32'(load_val), 32'(m_reg)));

    // A write landing on a wrap/clr edge goes straight into m_reg.
    always_comb begin
        m_next      = m_reg;
        pend_next   = m_pend;
        shadow_next = shadow;
        if (m_ok) begin
            shadow_next = m_val;
            pend_next   = 1'b1;
        end
        if (boundary) begin
            pend_next = 1'b0;
            if (m_ok) begin
                m_next = m_val;
            end else if (m_pend) begin
                m_next = shadow;
            end
        end
    end

    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = q_load;
        end else if (step) begin
            if (dir == DIR_UP) begin
                q_next = at_edge ? '0 : (q + W'(1));
            end else begin
                q_next = at_edge ? (m_next - W'(1)) : (q - W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q      <= '0;
            m_reg  <= M_RST;
            shadow <= M_RST;
            m_pend <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            q      <= q_next;
            m_reg  <= m_next;
            shadow <= shadow_next;
            m_pend <= pend_next;
            wrap   <= wrap_step;
        end
    end

endmodule
